fu_issue_arbiter: RTL and testbench

- Shares one execution unit (the ALU with an attached long-latency path) among NUM_REQ reservation-station requesters in the out-of-order core.
- Sits between the reservation stations, which are fed by the decode/control stage, and the execution unit.
- Picks one ready requester per cycle using round-robin priority.
- Blocks further issue while a long-latency op occupies the unit, and stops issuing when the CDB stalls.

---
 rtl/fu_issue_arbiter.sv | 107 ++++++++++
 tb/tb_fu_issue_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fu_issue_arbiter.sv
// Round-robin issue arbiter sharing one execution unit among NUM_REQ reservation stations.
// A long-latency grant blocks further issue for LONG_LAT cycles; cdb_stall holds off new issue.
module fu_issue_arbiter #(
    parameter  int NUM_REQ  = 4,
    parameter  int LONG_LAT = 8,
    localparam int IDX_W    = $clog2(NUM_REQ),
    localparam int CNT_W    = $clog2(LONG_LAT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] long_op,
    input  logic               cdb_stall,
    output logic [NUM_REQ-1:0] grant,
    output logic               issue_valid,
    output logic [IDX_W-1:0]   issue_idx,
    output logic               issue_long,
    output logic               fu_busy,
    output logic [CNT_W-1:0]   busy_cnt
);

    typedef enum logic {
        READY,
        LONG_BUSY
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   busy_cnt_q, busy_cnt_d;

    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   cand;
    int                 probe;
    logic               grant_en;

    // Rotating priority search starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write so no latch is inferred.
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        probe     = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            probe = int'(rr_ptr_q) + off;
            if (probe >= NUM_REQ) begin
                probe = probe - NUM_REQ;
            end
            cand = IDX_W'(probe);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Reset gates the combinational grant so nothing issues while reset is held.
    assign grant_en    = !reset && (state_q == READY) && !cdb_stall && sel_found;
    assign grant       = grant_en ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx) : '0;
    assign issue_valid = grant_en;
    assign issue_idx   = grant_en ? sel_idx : '0;
    assign issue_long  = grant_en & long_op[sel_idx];
    assign fu_busy     = (state_q == LONG_BUSY);
    assign busy_cnt    = busy_cnt_q;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        busy_cnt_d = busy_cnt_q;
        unique case (state_q)
            READY: begin
                if (grant_en) begin
                    rr_ptr_d = (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
                    if (long_op[sel_idx]) begin
                        state_d    = LONG_BUSY;
                        busy_cnt_d = CNT_W'(LONG_LAT - 1);
                    end
                end
            end
            LONG_BUSY: begin
                // Countdown ignores cdb_stall; the unit drains regardless of writeback pressure.
                busy_cnt_d = busy_cnt_q - CNT_W'(1);
                if (busy_cnt_q == CNT_W'(1)) begin
                    state_d = READY;
                end
            end
            default: begin
                state_d    = READY;
                busy_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= READY;
            rr_ptr_q   <= '0;
            busy_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Self-checking bench for fu_issue_arbiter: directed scenarios followed by randomized traffic,
// all compared against a counter-based reference model of the arbitration rules.
module tb_fu_issue_arbiter;

    localparam int N  = 4;
    localparam int LL = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] long_op;
    logic         cdb_stall;
    logic [N-1:0] grant;
    logic         issue_valid;
    logic [1:0]   issue_idx;
    logic         issue_long;
    logic         fu_busy;
    logic [2:0]   busy_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: next index to favour and remaining blocked cycles.
    int m_ptr  = 0;
    int m_busy = 0;
    int waits[N];

    fu_issue_arbiter #(.NUM_REQ(N), .LONG_LAT(LL)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .long_op    (long_op),
        .cdb_stall  (cdb_stall),
        .grant      (grant),
        .issue_valid(issue_valid),
        .issue_idx  (issue_idx),
        .issue_long (issue_long),
        .fu_busy    (fu_busy),
        .busy_cnt   (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit bit_of(input logic [N-1:0] v, input int i);
        return ((v >> i) & 1) != 0;
    endfunction

    // Drive one cycle's inputs at the falling edge, check outputs, advance the model, wait the rising edge.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] lo, input logic st, output int gk);
        logic [N-1:0] eg;
        int c;
        @(negedge clk);
        req       = r;
        long_op   = lo;
        cdb_stall = st;
        #1;
        gk = -1;
        if (!reset && m_busy == 0 && !st) begin
            for (int o = 0; o < N; o++) begin
                c = (m_ptr + o) % N;
                if (gk < 0 && bit_of(r, c)) gk = c;
            end
        end
        eg = (gk < 0) ? '0 : (N'(1) << gk);
        check("grant",       32'(grant),       32'(eg));
        check("issue_valid", 32'(issue_valid), 32'(gk >= 0));
        check("issue_idx",   32'(issue_idx),   (gk >= 0) ? 32'(gk) : 32'd0);
        check("issue_long",  32'(issue_long),  32'((gk >= 0) && bit_of(lo, gk)));
        check("fu_busy",     32'(fu_busy),     32'(!reset && m_busy > 0));
        check("busy_cnt",    32'(busy_cnt),    reset ? 32'd0 : 32'(m_busy));
        if (reset) begin
            m_ptr  = 0;
            m_busy = 0;
        end else if (gk >= 0) begin
            m_ptr  = (gk + 1) % N;
            m_busy = bit_of(lo, gk) ? LL - 1 : 0;
        end else if (m_busy > 0) begin
            m_busy--;
        end
        @(posedge clk);
    endtask

    initial begin
        int g;
        logic [N-1:0] pend;
        logic [N-1:0] lop;
        logic         st;

        reset     = 1'b0;
        req       = '0;
        long_op   = '0;
        cdb_stall = 1'b0;
        #1 reset  = 1'b1;

        // Outputs stay quiet under reset even with every request raised.
        step(4'b1111, 4'b0000, 1'b0, g);
        step(4'b1111, 4'b0000, 1'b0, g);
        #2 reset = 1'b0;

        // Fair rotation: 0,1,2,3,0.
        repeat (5) step(4'b1111, 4'b0000, 1'b0, g);

        // Grant 1 (ptr -> 2), then 0011 must wrap to requester 0.
        step(4'b0010, 4'b0000, 1'b0, g);
        step(4'b0011, 4'b0000, 1'b0, g);
        check("wrap_grant_idx", 32'(g), 32'd0);

        // Long op on requester 1 blocks seven cycles, then requester 2 wins.
        step(4'b0010, 4'b0010, 1'b0, g);
        repeat (7) step(4'b1111, 4'b0000, 1'b0, g);
        step(4'b1111, 4'b0000, 1'b0, g);
        check("post_long_idx", 32'(g), 32'd2);

        // Stall suppresses issue in READY without moving the pointer.
        repeat (3) step(4'b0100, 4'b0000, 1'b1, g);
        step(4'b0100, 4'b0000, 1'b0, g);
        check("post_stall_idx", 32'(g), 32'd2);

        // Countdown keeps running while the CDB is stalled.
        step(4'b0001, 4'b0001, 1'b0, g);
        repeat (2) step(4'b0000, 4'b0000, 1'b0, g);
        repeat (5) step(4'b1111, 4'b0000, 1'b1, g);
        step(4'b1111, 4'b0000, 1'b1, g);
        check("drained_busy", 32'(busy_cnt), 32'd0);

        // Reset in the middle of a long op with busy_cnt at 4.
        step(4'b0010, 4'b0010, 1'b0, g);
        repeat (3) step(4'b1010, 4'b0000, 1'b0, g);
        #2;
        reset = 1'b1;
        req   = 4'b1010;
        #1;
        check("rst_grant",    32'(grant),    32'd0);
        check("rst_fu_busy",  32'(fu_busy),  32'd0);
        check("rst_busy_cnt", 32'(busy_cnt), 32'd0);
        m_ptr  = 0;
        m_busy = 0;
        step(4'b1010, 4'b0000, 1'b0, g);
        #2 reset = 1'b0;
        step(4'b1010, 4'b0000, 1'b0, g);
        check("post_rst_idx", 32'(g), 32'd1);

        // Randomized traffic: requests held until granted, each granted within N grants.
        pend = '0;
        lop  = '0;
        for (int i = 0; i < N; i++) waits[i] = 0;
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i] = 1'b1;
                    lop[i]  = ($urandom_range(3, 0) == 0);
                end
            end
            st = ($urandom_range(4, 0) == 0);
            step(pend, lop, st, g);
            if (g >= 0) begin
                check("starvation", 32'(waits[g] < N), 32'd1);
                for (int i = 0; i < N; i++) if (pend[i] && i != g) waits[i]++;
                waits[g] = 0;
                pend[g]  = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
